// File: rtl/serial_add_ctrl_pkg.sv
// serial_add_defs: shared state encoding and default width for serial_add_ctrl.
package serial_add_defs;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
  localparam int DEF_WIDTH = 8;
  typedef enum logic [1:0] {IDLE = ST_IDLE, RUN = ST_RUN, DONE = ST_DONE} state_e;
endpackage

// File: rtl/serial_add_ctrl_fa_bit_cell.sv
// fa_bit_cell: combinational 1-bit full adder built from a 3-to-8 minterm decode.
module fa_bit_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  logic [7:0] m;
  assign m  = 8'd1 << {a, b, ci};
  assign s  = m[1] | m[2] | m[4] | m[7];
  assign co = m[3] | m[5] | m[6] | m[7];
endmodule

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder sequencing one full-adder cell over WIDTH cycles.
// Optional signed overflow output ovf enabled by defining SERIAL_ADD_OVF_EN.
module serial_add_ctrl
  import serial_add_defs::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);
  localparam int CW = $clog2(WIDTH);
  state_e state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, s_q, s_d, sum_q, sum_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic carry_q, carry_d, busy_q, busy_d, done_q, done_d, cout_q, cout_d, ovf_q, ovf_d;
  logic cs, cc, last;
  fa_bit_cell u_cell (.a(a_q[0]), .b(b_q[0]), .ci(carry_q), .s(cs), .co(cc));
  assign last = cnt_q == CW'(WIDTH - 1);
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: if (start) begin
        a_d     = a;
        b_d     = b;
        carry_d = cin;
        cnt_d   = '0;
        busy_d  = 1'b1;
        state_d = RUN;
      end
      RUN: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        s_d     = {cs, s_q[WIDTH-1:1]};
        carry_d = cc;
        cnt_d   = last ? cnt_q : cnt_q + 1'b1;
        // carry_q is the carry into the MSB while the last bit is processed
        if (last) begin
          state_d = DONE;
          done_d  = 1'b1;
          sum_d   = {cs, s_q[WIDTH-1:1]};
          cout_d  = cc;
          ovf_d   = carry_q ^ cc;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end
  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
`ifdef SERIAL_ADD_OVF_EN
  assign ovf = ovf_q;
`else
  logic unused_ovf;
  assign unused_ovf = ovf_q;
`endif
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: directed self-checking bench for serial_add_ctrl (WIDTH=8 and WIDTH=2).
module tb_serial_add_ctrl;
  logic clk = 1'b0, rst = 1'b1;
  logic start8 = 1'b0, cin8 = 1'b0, busy8, done8, cout8;
  logic [7:0] a8 = '0, b8 = '0, sum8;
  logic start2 = 1'b0, cin2 = 1'b0, busy2, done2, cout2;
  logic [1:0] a2 = '0, b2 = '0, sum2;
  int total = 0, bad = 0;
`ifdef SERIAL_ADD_OVF_EN
  logic ovf8, ovf2;
`endif
  always #5 clk = ~clk;
  serial_add_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
`ifdef SERIAL_ADD_OVF_EN
    , .ovf(ovf8)
`endif
  );
  serial_add_ctrl #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2), .cin(cin2),
    .busy(busy2), .done(done2), .sum(sum2), .cout(cout2)
`ifdef SERIAL_ADD_OVF_EN
    , .ovf(ovf2)
`endif
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic run8(input logic [7:0] ai, input logic [7:0] bi, input logic ci, output int lat);
    a8 = ai; b8 = bi; cin8 = ci; start8 = 1'b1;
    tick;
    start8 = 1'b0;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      tick;
      if (done8) begin
        lat = i;
        break;
      end
    end
    tick;
  endtask
  task automatic test_reset;
    rst = 1'b1;
    tick; tick;
    total++; if (busy8 !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy8); end
    total++; if (done8 !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done8); end
    total++; if ({cout8, sum8} !== 9'h000) begin bad++; $display("FAIL reset_sum got=%h exp=000", {cout8, sum8}); end
    rst = 1'b0;
    tick;
  endtask
  task automatic test_basic;
    a8 = 8'hFF; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
    tick;
    start8 = 1'b0;
    total++; if (busy8 !== 1'b1) begin bad++; $display("FAIL basic_busy0 got=%b exp=1", busy8); end
    for (int i = 1; i <= 8; i++) begin
      tick;
      total++; if (done8 !== (i == 8)) begin bad++; $display("FAIL basic_done cyc=%0d got=%b exp=%b", i, done8, i == 8); end
      total++; if (busy8 !== 1'b1) begin bad++; $display("FAIL basic_busy cyc=%0d got=%b exp=1", i, busy8); end
      if (i == 4) begin
        total++; if (sum8 !== 8'h00) begin bad++; $display("FAIL basic_partial got=%h exp=00", sum8); end
      end
    end
    total++; if (sum8 !== 8'h00) begin bad++; $display("FAIL basic_sum got=%h exp=00", sum8); end
    total++; if (cout8 !== 1'b1) begin bad++; $display("FAIL basic_cout got=%b exp=1", cout8); end
    tick;
    total++; if (done8 !== 1'b0) begin bad++; $display("FAIL basic_done_end got=%b exp=0", done8); end
    total++; if (busy8 !== 1'b0) begin bad++; $display("FAIL basic_busy_end got=%b exp=0", busy8); end
  endtask
  task automatic test_hold;
    int lat;
    a8 = 8'h5A; b8 = 8'h3C; cin8 = 1'b1; start8 = 1'b1;
    tick;
    start8 = 1'b0;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
      tick;
      if (done8) begin
        lat = i;
        break;
      end
    end
    total++; if (lat != 8) begin bad++; $display("FAIL hold_latency got=%0d exp=8", lat); end
    total++; if (sum8 !== 8'h97) begin bad++; $display("FAIL hold_sum got=%h exp=97", sum8); end
    total++; if (cout8 !== 1'b0) begin bad++; $display("FAIL hold_cout got=%b exp=0", cout8); end
    tick;
  endtask
  task automatic test_back_to_back;
    int n, t1, t2;
    a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0; start8 = 1'b1;
    tick;
    n = 0; t1 = -1; t2 = -1;
    for (int t = 1; t <= 20; t++) begin
      tick;
      if (done8) begin
        n++;
        if (t1 < 0) t1 = t; else t2 = t;
      end
    end
    start8 = 1'b0;
    total++; if (n != 2) begin bad++; $display("FAIL b2b_count got=%0d exp=2", n); end
    total++; if (t1 != 8) begin bad++; $display("FAIL b2b_first got=%0d exp=8", t1); end
    total++; if (t2 != 18) begin bad++; $display("FAIL b2b_second got=%0d exp=18", t2); end
    total++; if (sum8 !== 8'h46) begin bad++; $display("FAIL b2b_sum got=%h exp=46", sum8); end
    repeat (12) tick;
  endtask
  task automatic test_abort;
    int n, lat;
    a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1; start8 = 1'b1;
    tick;
    start8 = 1'b0;
    repeat (3) tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    total++; if (busy8 !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b exp=0", busy8); end
    total++; if (done8 !== 1'b0) begin bad++; $display("FAIL abort_done got=%b exp=0", done8); end
    total++; if ({cout8, sum8} !== 9'h000) begin bad++; $display("FAIL abort_sum got=%h exp=000", {cout8, sum8}); end
    n = 0;
    for (int i = 0; i < 15; i++) begin
      tick;
      if (done8) n++;
    end
    total++; if (n != 0) begin bad++; $display("FAIL abort_no_done got=%0d exp=0", n); end
    run8(8'h01, 8'h02, 1'b0, lat);
    total++; if (lat != 8 || sum8 !== 8'h03) begin bad++; $display("FAIL abort_recover lat=%0d sum=%h exp lat=8 sum=03", lat, sum8); end
  endtask
  task automatic test_width2;
    int lat;
    logic [2:0] e;
    for (int x = 0; x < 4; x++)
      for (int y = 0; y < 4; y++)
        for (int c = 0; c < 2; c++) begin
          a2 = 2'(x); b2 = 2'(y); cin2 = 1'(c); start2 = 1'b1;
          e = 3'(x + y + c);
          tick;
          start2 = 1'b0;
          lat = -1;
          for (int i = 1; i <= 6; i++) begin
            tick;
            if (done2) begin
              lat = i;
              break;
            end
          end
          total++;
          if (lat != 2 || {cout2, sum2} !== e) begin
            bad++;
            $display("FAIL w2 a=%0d b=%0d c=%0d got=%0d lat=%0d exp=%0d lat=2", x, y, c, {cout2, sum2}, lat, e);
          end
          tick;
        end
  endtask
`ifdef SERIAL_ADD_OVF_EN
  task automatic test_ovf;
    int lat;
    run8(8'h7F, 8'h01, 1'b0, lat);
    total++; if ({cout8, sum8, ovf8} !== {1'b0, 8'h80, 1'b1}) begin bad++; $display("FAIL ovf_7f got c=%b s=%h v=%b exp c=0 s=80 v=1", cout8, sum8, ovf8); end
    run8(8'h80, 8'h80, 1'b0, lat);
    total++; if ({cout8, sum8, ovf8} !== {1'b1, 8'h00, 1'b1}) begin bad++; $display("FAIL ovf_80 got c=%b s=%h v=%b exp c=1 s=00 v=1", cout8, sum8, ovf8); end
    run8(8'hFF, 8'h01, 1'b0, lat);
    total++; if (ovf8 !== 1'b0) begin bad++; $display("FAIL ovf_ff got=%b exp=0", ovf8); end
  endtask
`endif
  initial begin
    test_reset;
    test_basic;
    test_hold;
    test_back_to_back;
    test_abort;
    test_width2;
`ifdef SERIAL_ADD_OVF_EN
    test_ovf;
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
- Bit-serial adder controller: sequences a single 1-bit decoder-style full-adder cell over WIDTH cycles to add two WIDTH-bit operands.
- Trades latency for area, so one full-adder cell serves an entire word.
- Sits between a requester (start/operands) and downstream logic that consumes sum/cout on a done pulse.

Parameters:
- WIDTH, 8, operand width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  operand A, captured on accepted start.
- b  input  WIDTH  operand B, captured on accepted start.
- cin  input  1  carry-in, captured on accepted start.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse; sum/cout valid.
- sum  output  WIDTH  registered result; holds until the next completion or reset.
- cout  output  1  registered carry-out; holds with sum.

Behaviour:
- Interface (already decided): one clock; reset is synchronous and active-high. Port names are clk and rst.
- Reset: state=IDLE. busy=0, done=0, sum=0, cout=0. Shift registers, carry register and bit counter are cleared.
- rst has priority over all other inputs in every state. Reset mid-RUN aborts the operation and discards the partial sum; the next cycle is IDLE.
- FSM states: IDLE, RUN, DONE.
- IDLE, start=1 at edge k:
  - load a_sh<=a, b_sh<=b, carry<=cin, cnt<=0, go to RUN.
  - start=0 stays in IDLE.
- RUN, edges k+1..k+WIDTH, one bit per edge, LSB first:
  - cell inputs are {a_sh[0], b_sh[0], carry}.
  - s_sh shifts right with the cell sum inserted at the MSB.
  - a_sh and b_sh shift right; carry<=cell carry; cnt<=cnt+1.
- Exit RUN: on the edge where cnt==WIDTH-1, go to DONE. On that same edge, sum<=final shifted value, cout<=final carry, done<=1.
- DONE: lasts exactly one cycle, then IDLE with done<=0.
- Latency: start sampled at edge k; done high during the cycle after edge k+WIDTH.
- Throughput: the earliest next accepted start is at edge k+WIDTH+2.
- start while busy (RUN or DONE) is ignored: not queued, no effect on the operation in flight.
- Operands and cin are sampled only at acceptance. Changes to a, b or cin during RUN have no effect.
- sum/cout never show partial results. They change only on the completion edge or on reset.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1). There is no saturation.
- Counter width: clog2(WIDTH). cnt never wraps, because the exit condition is cnt==WIDTH-1.

Optional Feature:
- Macro: SERIAL_ADD_OVF_EN.
- When defined:
  - adds output port ovf (1 bit), the signed two's-complement overflow = carry into MSB XOR carry out of MSB.
  - ovf is registered alongside cout, updated on the completion edge, held otherwise, and reset to 0.
  - requires one extra carry flop capturing the carry into the MSB.
- When undefined: the ovf port and its logic are absent. All other behaviour is identical.

Decomposition:
- Shared package/header serial_add_defs:
  - state encoding localparams ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2.
  - default width constant.
- One sub-module: fa_bit_cell.
  - combinational 1-bit full adder built from a 3-to-8 minterm decode.
  - sum = OR of minterms 1,2,4,7; carry = OR of minterms 3,5,6,7.
  - instantiated once by serial_add_ctrl.

Test Plan:
1. WIDTH=8, a=8'hFF, b=8'h01, cin=0, start at edge k -> done only in the cycle after edge k+8; sum=8'h00, cout=1; busy high over edges k+1..k+9 window then low.
2. a=8'h5A, b=8'h3C, cin=1 -> sum=8'h97, cout=0. Change a/b every cycle during RUN -> result unchanged.
3. start held high continuously from IDLE:
   - first op accepted at k; starts at k+1..k+9 ignored.
   - second op accepted at k+10.
   - exactly one done per operation, 10 cycles apart.
4. rst=1 at edge k+4 of a RUN -> next cycle IDLE with busy=0, done=0, sum=0, cout=0; no done pulse ever follows.
5. Exhaustive at WIDTH=2: all a, b, cin combinations (32 ops) -> {cout,sum}==a+b+cin.
6. With SERIAL_ADD_OVF_EN:
   - 8'h7F+8'h01 -> sum=8'h80, cout=0, ovf=1.
   - 8'h80+8'h80 -> sum=8'h00, cout=1, ovf=1.
   - 8'hFF+8'h01 -> ovf=0.
